// File: rtl/r_response_memory.sv
// r_response_memory
//   Parking store for R-channel beats that the ID ordering unit cannot
//   forward yet. Beats are grouped per uid into burst slots and are handed
//   back in arrival order when the ordering unit asks for that uid.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   store_*         store side: valid/ready handshake with id, data, resp, last
//   release_uid     uid the ordering unit wants next
//   release_ready   pop the presented beat
//   release_valid   a parked beat of release_uid is presented
//   release_data/resp/last  presented beat (zero when !release_valid)
//   slots_used      registered count of non-free slots
//   overflow_err    sticky: a burst ran past MAX_LEN beats without last
module r_response_memory #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int NUM_SLOTS  = 4,
  parameter int MAX_LEN    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             store_valid,
  output logic                             store_ready,
  input  logic [ID_WIDTH-1:0]              store_id,
  input  logic [DATA_WIDTH-1:0]            store_data,
  input  logic [RESP_WIDTH-1:0]            store_resp,
  input  logic                             store_last,
  input  logic [ID_WIDTH-1:0]              release_uid,
  input  logic                             release_ready,
  output logic                             release_valid,
  output logic [DATA_WIDTH-1:0]            release_data,
  output logic [RESP_WIDTH-1:0]            release_resp,
  output logic                             release_last,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   slots_used,
  output logic                             overflow_err
);

  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int USED_W = $clog2(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {S_FREE, S_FILLING, S_COMPLETE} slot_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } beat_t;

  slot_state_e         state  [NUM_SLOTS];
  logic [ID_WIDTH-1:0] uid    [NUM_SLOTS];
  logic [CNT_W-1:0]    wr_cnt [NUM_SLOTS];
  logic [CNT_W-1:0]    rd_cnt [NUM_SLOTS];
  beat_t               mem    [NUM_SLOTS][MAX_LEN];

  logic              st_hit, free_hit, rl_hit;
  logic [SLOT_W-1:0] st_idx, free_idx, rl_idx;
  logic              st_room, store_fire, pop, pop_last;
  logic [SLOT_W-1:0] wr_slot;
  logic [IDX_W-1:0]  wr_idx;
  logic [USED_W-1:0] used_now;
  beat_t             rd_beat;

  // Lowest-index priority for store match, free allocation and release match.
  always_comb begin
    st_hit   = 1'b0;
    st_idx   = '0;
    free_hit = 1'b0;
    free_idx = '0;
    rl_hit   = 1'b0;
    rl_idx   = '0;
    used_now = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!st_hit && state[i] == S_FILLING && uid[i] == store_id) begin
        st_hit = 1'b1;
        st_idx = SLOT_W'(i);
      end
      if (!free_hit && state[i] == S_FREE) begin
        free_hit = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (!rl_hit && state[i] != S_FREE && uid[i] == release_uid) begin
        rl_hit = 1'b1;
        rl_idx = SLOT_W'(i);
      end
      if (state[i] != S_FREE) used_now = used_now + USED_W'(1);
    end
  end

  always_comb begin
    st_room       = st_hit && (wr_cnt[st_idx] < LEN_MAX);
    store_ready   = st_hit ? st_room : free_hit;
    store_fire    = store_valid && store_ready;
    wr_slot       = st_hit ? st_idx : free_idx;
    wr_idx        = st_hit ? wr_cnt[st_idx][IDX_W-1:0] : '0;

    release_valid = rl_hit && (rd_cnt[rl_idx] < wr_cnt[rl_idx]);
    rd_beat       = mem[rl_idx][rd_cnt[rl_idx][IDX_W-1:0]];
    release_data  = release_valid ? rd_beat.data : '0;
    release_resp  = release_valid ? rd_beat.resp : '0;
    release_last  = release_valid ? rd_beat.last : 1'b0;
    pop           = release_valid && release_ready;
    pop_last      = pop && rd_beat.last;
  end

  // Beat storage carries no reset; the counters alone define what is valid.
  always_ff @(posedge clk) begin
    if (store_fire) begin
      mem[wr_slot][wr_idx] <= '{data: store_data, resp: store_resp, last: store_last};
    end
  end

  // A popped last beat frees the slot. That slot is still non-FREE in this
  // cycle's allocation search, so it only becomes allocatable next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        state[i]  <= S_FREE;
        uid[i]    <= '0;
        wr_cnt[i] <= '0;
        rd_cnt[i] <= '0;
      end
      slots_used   <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (store_fire && wr_slot == SLOT_W'(i)) begin
          if (st_hit) begin
            wr_cnt[i] <= wr_cnt[i] + CNT_W'(1);
          end else begin
            uid[i]    <= store_id;
            wr_cnt[i] <= CNT_W'(1);
          end
          state[i] <= store_last ? S_COMPLETE : S_FILLING;
        end
        if (pop && rl_idx == SLOT_W'(i)) begin
          if (pop_last) begin
            state[i]  <= S_FREE;
            wr_cnt[i] <= '0;
            rd_cnt[i] <= '0;
          end else begin
            rd_cnt[i] <= rd_cnt[i] + CNT_W'(1);
          end
        end
      end
      // Registered count trails slot state changes by one cycle.
      slots_used <= used_now;
      if (store_valid && st_hit && !st_room) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_r_response_memory.sv
// Directed bench for r_response_memory with a per-uid ordered scoreboard.
module tb_r_response_memory;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int RW = 2;
  localparam int NS = 4;
  localparam int ML = 8;
  localparam logic [IW-1:0] NOUID = 4'hF;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_valid;
  logic          store_ready;
  logic [IW-1:0] store_id;
  logic [DW-1:0] store_data;
  logic [RW-1:0] store_resp;
  logic          store_last;
  logic [IW-1:0] release_uid;
  logic          release_ready;
  logic          release_valid;
  logic [DW-1:0] release_data;
  logic [RW-1:0] release_resp;
  logic          release_last;
  logic [$clog2(NS+1)-1:0] slots_used;
  logic          overflow_err;

  always #5 clk = ~clk;

  r_response_memory #(
    .ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .NUM_SLOTS(NS), .MAX_LEN(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .store_valid(store_valid), .store_ready(store_ready), .store_id(store_id),
    .store_data(store_data), .store_resp(store_resp), .store_last(store_last),
    .release_uid(release_uid), .release_ready(release_ready),
    .release_valid(release_valid), .release_data(release_data),
    .release_resp(release_resp), .release_last(release_last),
    .slots_used(slots_used), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [IW-1:0] uid;
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive both sides, check at the falling edge, advance.
  task automatic step(input bit sv, input logic [IW-1:0] sid, input logic [DW-1:0] sd,
                      input bit sl, input bit exp_sready,
                      input bit rr, input logic [IW-1:0] rid, input bit exp_rvalid);
    int k;
    logic [RW-1:0] sr;
    sr = sd[1:0];
    store_valid   = sv;
    store_id      = sid;
    store_data    = sd;
    store_resp    = sr;
    store_last    = sl;
    release_uid   = rid;
    release_ready = rr;
    @(negedge clk);
    if (sv) chk("store_ready", store_ready, exp_sready);
    chk("release_valid", release_valid, exp_rvalid);
    if (exp_rvalid) begin
      k = -1;
      foreach (sb[j]) if (k < 0 && sb[j].uid == rid) k = j;
      n_assert++;
      assert (k >= 0) else begin
        n_fail++;
        $error("FAIL sb_lookup: observed no queued beat expected one for uid 0x%0h", rid);
      end
      if (k >= 0) begin
        chk("release_data", release_data, sb[k].data);
        chk("release_resp", release_resp, sb[k].resp);
        chk("release_last", release_last, sb[k].last);
        if (rr) sb.delete(k);
      end
    end else begin
      chk("release_data_zero", release_data, 0);
      chk("release_last_zero", release_last, 0);
    end
    if (sv && exp_sready) sb.push_back('{sid, sd, sr, sl});
    @(posedge clk);
    #1;
    store_valid   = 1'b0;
    release_ready = 1'b0;
  endtask

  task automatic st(input logic [IW-1:0] id, input logic [DW-1:0] d, input bit l);
    step(1'b1, id, d, l, 1'b1, 1'b0, NOUID, 1'b0);
  endtask

  task automatic rel(input logic [IW-1:0] id, input bit v);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, id, v);
  endtask

  task automatic idle(input int n);
    store_valid   = 1'b0;
    release_ready = 1'b0;
    release_uid   = NOUID;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    store_valid = 1'b0; store_id = '0; store_data = '0; store_resp = '0; store_last = 1'b0;
    release_uid = NOUID; release_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_store_ready", store_ready, 1);
    chk("rst_release_valid", release_valid, 0);
    chk("rst_slots_used", slots_used, 0);
    chk("rst_overflow", overflow_err, 0);

    // Three-beat burst, then drained back-to-back.
    st(4'h5, 32'hD000_0000, 1'b0);
    st(4'h5, 32'hD000_0001, 1'b0);
    st(4'h5, 32'hD000_0002, 1'b1);
    idle(1);
    chk("slots_used_one", slots_used, 1);
    rel(4'h5, 1'b1);
    rel(4'h5, 1'b1);
    rel(4'h5, 1'b1);
    idle(2);
    chk("slots_used_zero_after_drain", slots_used, 0);

    // Partial release of a filling slot; no store-to-release bypass.
    st(4'h3, 32'hA000_0000, 1'b0);
    rel(4'h3, 1'b1);
    rel(4'h3, 1'b0);
    step(1'b1, 4'h3, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0);
    rel(4'h3, 1'b1);
    rel(4'h3, 1'b0);

    // Fill all slots; a freed slot is allocatable only the following cycle.
    st(4'h1, 32'h1111_1111, 1'b1);
    st(4'h2, 32'h2222_2222, 1'b1);
    st(4'h3, 32'h3333_3333, 1'b1);
    st(4'h4, 32'h4444_4444, 1'b1);
    idle(2);
    chk("slots_used_full", slots_used, 4);
    step(1'b1, 4'h6, 32'h6666_6666, 1'b1, 1'b0, 1'b0, NOUID, 1'b0);
    step(1'b1, 4'h6, 32'h6666_6666, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1);
    step(1'b1, 4'h6, 32'h6666_6666, 1'b1, 1'b1, 1'b0, NOUID, 1'b0);
    rel(4'h6, 1'b1);
    rel(4'h1, 1'b1);
    rel(4'h3, 1'b1);
    rel(4'h4, 1'b1);
    idle(2);
    chk("slots_used_empty", slots_used, 0);

    // Interleaved bursts keep their own ordering.
    for (int i = 0; i < 3; i++) begin
      st(4'h7, 32'h7700_0000 + $urandom_range(0, 255) * 4 + i, i == 2);
      st(4'h9, 32'h9900_0000 + $urandom_range(0, 255) * 4 + i, i == 2);
    end
    for (int i = 0; i < 3; i++) rel(4'h9, 1'b1);
    rel(4'h9, 1'b0);
    for (int i = 0; i < 3; i++) rel(4'h7, 1'b1);

    // Store and pop the same slot in one cycle.
    st(4'hB, 32'hB000_0000, 1'b0);
    st(4'hB, 32'hB000_0001, 1'b0);
    rel(4'hB, 1'b1);
    step(1'b1, 4'hB, 32'hB000_0002, 1'b0, 1'b1, 1'b1, 4'hB, 1'b1);
    step(1'b1, 4'hB, 32'hB000_0003, 1'b1, 1'b1, 1'b1, 4'hB, 1'b1);
    rel(4'hB, 1'b1);
    rel(4'hB, 1'b0);

    // Overflow: MAX_LEN beats without last, then one more.
    for (int i = 0; i < ML; i++) st(4'hA, 32'hAA00_0000 + i, 1'b0);
    chk("overflow_before", overflow_err, 0);
    step(1'b1, 4'hA, 32'hAA00_00FF, 1'b0, 1'b0, 1'b0, NOUID, 1'b0);
    chk("overflow_set", overflow_err, 1);
    idle(2);
    chk("overflow_sticky", overflow_err, 1);
    step(1'b1, 4'hA, 32'hAA00_00FF, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1);
    chk("overflow_still", overflow_err, 1);

    // Reset mid-burst discards everything.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("rst2_overflow", overflow_err, 0);
    chk("rst2_slots_used", slots_used, 0);
    chk("rst2_store_ready", store_ready, 1);
    rel(4'hA, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/r_response_memory.md
Name: r_response_memory

Overview:
Out-of-order read-response parking store. It sits beside the R-channel ID ordering unit. It accepts response beats the ordering unit cannot forward yet, tagged by unique id (uid = {row,col}). It returns those beats in arrival order per uid when the ordering unit later requests that uid. Storage is a small pool of burst slots; each slot holds one full burst of up to MAX_LEN beats.

Parameters:
ID_WIDTH, 4, width of uid on both store and release sides
DATA_WIDTH, 32, R-beat data width
RESP_WIDTH, 2, R-beat resp width
NUM_SLOTS, 4, number of burst slots (max bursts parked at once)
MAX_LEN, 8, max beats per burst; slot depth

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
store_valid  in  1  beat offered for storage
store_ready  out  1  beat accepted this cycle if store_valid
store_id  in  ID_WIDTH  uid of offered beat
store_data  in  DATA_WIDTH  beat data
store_resp  in  RESP_WIDTH  beat resp
store_last  in  1  final beat of burst
release_uid  in  ID_WIDTH  uid requested for release
release_ready  in  1  request: pop the next beat of release_uid
release_valid  out  1  a stored beat of release_uid is available
release_data  out  DATA_WIDTH  beat data (0 when !release_valid)
release_resp  out  RESP_WIDTH  beat resp (0 when !release_valid)
release_last  out  1  beat is burst's last (0 when !release_valid)
slots_used  out  $clog2(NUM_SLOTS+1)  registered count of non-free slots
overflow_err  out  1  sticky: burst exceeded MAX_LEN without last

Behaviour:
- Reset is synchronous. All slots go FREE, every wr_cnt and rd_cnt goes to 0, slots_used=0, overflow_err=0. After reset, store_ready=1 (a slot is free) and release_valid=0.
- Per-slot state: FREE / FILLING / COMPLETE; uid; wr_cnt and rd_cnt (0..MAX_LEN, $clog2(MAX_LEN+1) bits); beat array [MAX_LEN] of {data,resp,last}.
- Store match: the lowest-index slot in FILLING with uid==store_id.
- Store rules:
  - If a match exists and wr_cnt<MAX_LEN, write the beat at index wr_cnt and increment wr_cnt.
  - If no match exists, allocate the lowest-index FREE slot. Write the beat at index 0, set wr_cnt=1 and load uid.
  - store_ready is combinational: (match & wr_cnt<MAX_LEN) | (!match & any FREE).
  - On an accepted beat with store_last=1, the slot goes to COMPLETE.
  - A matched slot with wr_cnt==MAX_LEN that receives store_valid sets overflow_err, which stays set until rst. store_ready stays low for that uid; there is no recovery except reset.
- Release match: the lowest-index non-FREE slot with uid==release_uid.
- Release rules:
  - release_valid = match & (rd_cnt<wr_cnt). This is combinational from registered state and release_uid; release_ready does not gate it.
  - Outputs come from beat[rd_cnt]. When release_valid=0, release_data, release_resp and release_last are 0.
  - Pop happens on release_valid & release_ready: rd_cnt increments. If the popped beat has last=1, the slot goes FREE next cycle and its counters clear.
  - A slot in FILLING may be released partially. When rd_cnt catches wr_cnt, release_valid drops until more beats arrive.
- Latency: a stored beat is visible to release on the cycle after its store handshake. There is no same-cycle bypass.
- Simultaneous events:
  - Store and pop on the same slot in the same cycle are both legal and both take effect; wr_cnt and rd_cnt update independently.
  - A slot freed by a pop cannot be allocated by a store in the same cycle; it is allocatable the next cycle.
  - Store to one slot and release from another slot proceed in parallel.
- Full: all slots non-FREE and store_id unmatched gives store_ready=0. Backpressure reaches the ordering unit; no beat is dropped.
- Uid reuse: the upstream allocator guarantees a uid is not reissued before its last beat is released. If two non-FREE slots share a uid, the lowest index wins for both store and release.
- slots_used updates one cycle after each allocation or free. Allocate and free in the same cycle leave it unchanged.
- Reset asserted mid-burst discards all stored beats; outputs return to reset values the next cycle.

Test Plan:
- Reset, then store uid 0x5 beats D0,D1,D2(last) -> store_ready=1 each cycle; slots_used=1. Release uid 0x5 with ready held -> D0,D1,D2 on consecutive cycles, last on D2; slots_used=0 two cycles after the last pop.
- Store uid 0x3 beat A0 (no last), request release 0x3 next cycle -> one A0 beat, then release_valid=0. Store A1(last) -> A1 valid the next cycle, then the slot frees.
- Fill 4 slots with uids 1,2,3,4 (single-beat, last), offer uid 6 -> store_ready=0. Pop uid 2 -> in the same cycle uid 6 is still stalled; the next cycle it is accepted into slot 1.
- Interleaved stores of uid 0x7 and 0x9 alternating beats, release 0x9 then 0x7 -> each uid returns its own beats in order; data is not mixed.
- Store and pop the same uid in the same cycle (wr_cnt=2, rd_cnt=1) -> wr_cnt=3, rd_cnt=2 the next cycle.
- Store 8 beats of uid 0xA without last, offer a 9th -> store_ready=0, overflow_err=1 and sticky; rst clears it and slots_used=0.
